mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL use one clock and one reset; reset is asynchronous and active-low.
REQ-002 Parameter: TIMEOUT, default 255, max cycles waiting for dmem_resp before abort.
REQ-003 clk  in  1  system clock, all state on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 req_valid  in  1  pipeline presents a memory op.
REQ-006 req_ready  out  1  block can accept an op this cycle.
REQ-007 req_load, req_store  in  1 each  op kind.
REQ-008 req_funct3  in  3  RV32I width/sign code: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  store data, right-aligned.
REQ-011 req_rd  in  5  destination register tag.
REQ-012 dmem_read, dmem_write  out  1 each  memory strobes.
REQ-013 dmem_address  out  32  word address, bits [1:0] always 0.
REQ-014 dmem_wmask  out  4  byte enables; dmem_wdata  out  32  lane-aligned store data.
REQ-015 dmem_rdata  in  32; dmem_resp  in  1  response (read data valid / write done).
REQ-016 wb_valid  out  1; wb_rd  out  5; wb_rdata  out  32  completed-op result.
REQ-017 err_misalign, err_illegal, err_timeout  out  1 each  one-cycle error pulses.

Function
REQ-018 States: IDLE, WAIT. req_ready = (state==IDLE); accept on req_valid && req_ready.
REQ-019 Accept in cycle N: op captured; dmem_read/dmem_write registered high from cycle N+1; state -> WAIT.
REQ-020 In WAIT, address, wmask, wdata and strobe SHALL be held stable until dmem_resp is sampled high.
REQ-021 dmem_resp sampled high in WAIT: strobes drop next cycle; wb_valid pulses one cycle next cycle, with wb_rd = captured tag; state -> IDLE, so req_ready is high in the same cycle as wb_valid.
REQ-022 Store mask, off = addr[1:0]: SB 4'b0001<<off; SH 4'b0011<<off; SW 4'b1111. dmem_wdata = req_wdata << (8*off) (byte/half replicated-by-shift only).
REQ-023 Load extract: LB/LBU byte off, sign-/zero-extended; LH/LHU half at off, sign-/zero-extended; LW full word. Stores return wb_rdata = 0.
REQ-024 Misaligned (half with addr[0]=1, word with addr[1:0]!=0): no memory access, err_misalign pulses cycle N+1, no wb_valid, remain IDLE.
REQ-025 Illegal (load && store, neither set, or funct3 not in REQ-008 for the kind): err_illegal pulses cycle N+1, no access, no wb_valid.
REQ-026 8-bit wait counter clears on entry to WAIT, increments each WAIT cycle without resp; at TIMEOUT: strobes drop, err_timeout pulses, no wb_valid, -> IDLE.
REQ-027 dmem_resp outside WAIT SHALL be ignored.
REQ-028 req_valid while req_ready low SHALL be ignored; the pipeline holds it.

Reset
REQ-029 rst_n low: state IDLE, counter 0, all outputs 0 except req_ready=1, immediately and regardless of clk.
REQ-030 Reset during WAIT abandons the op; no wb_valid or error pulse afterwards.

Structure
REQ-031 Package mem_access_pkg: funct3 enum, state enum, TIMEOUT default.
REQ-032 One combinational sub-module mau_align: mask/shift of store data and extract/extend of load data.

Verification
REQ-033 LW addr 0x100, mem word 0xDEADBEEF, resp 1 cycle after strobe -> wb_rdata 0xDEADBEEF, wb_valid 1 cycle after resp.
REQ-034 LB addr 0x103, same word -> wb_rdata 0xFFFFFFDE; LBU -> 0x000000DE; LHU addr 0x102 -> 0x0000DEAD.
REQ-035 SH addr 0x102 wdata 0x1234ABCD -> dmem_address 0x100, wmask 4'b1100, wdata 0xABCD0000; subsequent LW returns 0xABCDBEEF.
REQ-036 LW addr 0x101 -> err_misalign 1 cycle, no dmem_read; funct3 011 -> err_illegal.
REQ-037 Withhold dmem_resp for TIMEOUT cycles -> err_timeout pulse, strobes low, req_ready high.
REQ-038 Assert rst_n low mid-WAIT, then late resp -> all outputs 0, no wb_valid; back-to-back LW pair completes with no idle gap beyond REQ-021.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types for the memory access unit: funct3 codes, FSM states, timeout default,
// and request classification helpers used by the top-level.
package mem_access_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  localparam int unsigned TIMEOUT_DEFAULT = 255;
  localparam int          CNT_W           = 8;

  // Exactly one of load/store, and a width code that exists for that kind.
  function automatic logic f3_legal(input logic ld, input logic st, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    if (ld && !st) begin
      case (f3)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
        default:                        ok = 1'b0;
      endcase
    end else if (st && !ld) begin
      case (f3)
        F3_B, F3_H, F3_W: ok = 1'b1;
        default:          ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    case (f3)
      F3_H, F3_HU: mis = off[0];
      F3_W:        mis = (off != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline-side request/writeback/error signals plus data-memory port of the access unit.
// slave = the access unit itself, master = the pipeline/memory environment driving it.
interface mem_access_unit_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_load;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;

  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_address;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;

  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_rdata;

  logic        err_misalign;
  logic        err_illegal;
  logic        err_timeout;

  modport slave (
    input  req_valid, req_load, req_store, req_funct3, req_addr, req_wdata, req_rd,
    output req_ready,
    output dmem_read, dmem_write, dmem_address, dmem_wmask, dmem_wdata,
    input  dmem_rdata, dmem_resp,
    output wb_valid, wb_rd, wb_rdata,
    output err_misalign, err_illegal, err_timeout
  );

  modport master (
    output req_valid, req_load, req_store, req_funct3, req_addr, req_wdata, req_rd,
    input  req_ready,
    input  dmem_read, dmem_write, dmem_address, dmem_wmask, dmem_wdata,
    output dmem_rdata, dmem_resp,
    input  wb_valid, wb_rd, wb_rdata,
    input  err_misalign, err_illegal, err_timeout
  );

endinterface

// File: rtl/mau_align.sv
// Combinational lane logic: byte-enable/shift for stores, extract/extend for loads.
// Zero latency, no state, no backpressure.
module mau_align
  import mem_access_pkg::*;
(
  input  logic [2:0]  i_st_funct3,
  input  logic [1:0]  i_st_off,
  input  logic [31:0] i_st_wdata,
  output logic [3:0]  o_wmask,
  output logic [31:0] o_wdata,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_ld_rdata,
  output logic [31:0] o_rdata
);

  logic [31:0] w_ld_sh;

  assign o_wdata = i_st_wdata << {i_st_off, 3'b000};
  assign w_ld_sh = i_ld_rdata >> {i_ld_off, 3'b000};

  always_comb begin
    o_wmask = 4'b1111;
    case (i_st_funct3)
      F3_B:    o_wmask = 4'b0001 << i_st_off;
      F3_H:    o_wmask = 4'b0011 << i_st_off;
      default: o_wmask = 4'b1111;
    endcase
  end

  always_comb begin
    o_rdata = w_ld_sh;
    case (i_ld_funct3)
      F3_B:    o_rdata = {{24{w_ld_sh[7]}}, w_ld_sh[7:0]};
      F3_BU:   o_rdata = {24'h000000, w_ld_sh[7:0]};
      F3_H:    o_rdata = {{16{w_ld_sh[15]}}, w_ld_sh[15:0]};
      F3_HU:   o_rdata = {16'h0000, w_ld_sh[15:0]};
      default: o_rdata = w_ld_sh;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit: strobes 1 cycle after accept, writeback 1 cycle after dmem_resp.
// req_ready only in IDLE; errors pulse one cycle after accept; WAIT aborts after TIMEOUT resp-less cycles.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_access_unit_if.slave bus
);

  state_e             r_state, w_state;
  logic [CNT_W-1:0]   r_cnt, w_cnt;
  logic               r_read, w_read;
  logic               r_write, w_write;
  logic [31:0]        r_addr, w_addr;
  logic [3:0]         r_wmask, w_wmask;
  logic [31:0]        r_wdata, w_wdata;
  logic               r_is_load, w_is_load;
  logic [2:0]         r_funct3, w_funct3;
  logic [1:0]         r_off, w_off;
  logic [4:0]         r_rd, w_rd;
  logic               r_wb_valid, w_wb_valid;
  logic [4:0]         r_wb_rd, w_wb_rd;
  logic [31:0]        r_wb_rdata, w_wb_rdata;
  logic               r_err_mis, w_err_mis;
  logic               r_err_ill, w_err_ill;
  logic               r_err_to, w_err_to;

  logic               w_legal;
  logic               w_misal;
  logic [3:0]         w_st_mask;
  logic [31:0]        w_st_wdata;
  logic [31:0]        w_ld_rdata;

  assign w_legal = f3_legal(bus.req_load, bus.req_store, bus.req_funct3);
  assign w_misal = misaligned(bus.req_funct3, bus.req_addr[1:0]);

  // Store lanes come from the live request; load extraction uses the captured op.
  mau_align u_align (
    .i_st_funct3 (bus.req_funct3),
    .i_st_off    (bus.req_addr[1:0]),
    .i_st_wdata  (bus.req_wdata),
    .o_wmask     (w_st_mask),
    .o_wdata     (w_st_wdata),
    .i_ld_funct3 (r_funct3),
    .i_ld_off    (r_off),
    .i_ld_rdata  (bus.dmem_rdata),
    .o_rdata     (w_ld_rdata)
  );

  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_read     = r_read;
    w_write    = r_write;
    w_addr     = r_addr;
    w_wmask    = r_wmask;
    w_wdata    = r_wdata;
    w_is_load  = r_is_load;
    w_funct3   = r_funct3;
    w_off      = r_off;
    w_rd       = r_rd;
    w_wb_valid = 1'b0;
    w_wb_rd    = 5'd0;
    w_wb_rdata = 32'd0;
    w_err_mis  = 1'b0;
    w_err_ill  = 1'b0;
    w_err_to   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (!w_legal) begin
            w_err_ill = 1'b1;
          end else if (w_misal) begin
            w_err_mis = 1'b1;
          end else begin
            w_state   = S_WAIT;
            w_cnt     = '0;
            w_read    = bus.req_load;
            w_write   = bus.req_store;
            w_addr    = {bus.req_addr[31:2], 2'b00};
            w_wmask   = bus.req_store ? w_st_mask : 4'b0000;
            w_wdata   = bus.req_store ? w_st_wdata : 32'd0;
            w_is_load = bus.req_load;
            w_funct3  = bus.req_funct3;
            w_off     = bus.req_addr[1:0];
            w_rd      = bus.req_rd;
          end
        end
      end

      S_WAIT: begin
        if (bus.dmem_resp) begin
          w_state    = S_IDLE;
          w_read     = 1'b0;
          w_write    = 1'b0;
          w_wb_valid = 1'b1;
          w_wb_rd    = r_rd;
          w_wb_rdata = r_is_load ? w_ld_rdata : 32'd0;
        end else if ((32'(r_cnt) + 32'd1) >= TIMEOUT) begin
          // This was the TIMEOUT-th strobe cycle without a response.
          w_state  = S_IDLE;
          w_read   = 1'b0;
          w_write  = 1'b0;
          w_err_to = 1'b1;
        end else begin
          w_cnt = r_cnt + 8'd1;
        end
      end

      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_read     <= 1'b0;
      r_write    <= 1'b0;
      r_addr     <= 32'd0;
      r_wmask    <= 4'd0;
      r_wdata    <= 32'd0;
      r_is_load  <= 1'b0;
      r_funct3   <= 3'd0;
      r_off      <= 2'd0;
      r_rd       <= 5'd0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= 5'd0;
      r_wb_rdata <= 32'd0;
      r_err_mis  <= 1'b0;
      r_err_ill  <= 1'b0;
      r_err_to   <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_read     <= w_read;
      r_write    <= w_write;
      r_addr     <= w_addr;
      r_wmask    <= w_wmask;
      r_wdata    <= w_wdata;
      r_is_load  <= w_is_load;
      r_funct3   <= w_funct3;
      r_off      <= w_off;
      r_rd       <= w_rd;
      r_wb_valid <= w_wb_valid;
      r_wb_rd    <= w_wb_rd;
      r_wb_rdata <= w_wb_rdata;
      r_err_mis  <= w_err_mis;
      r_err_ill  <= w_err_ill;
      r_err_to   <= w_err_to;
    end
  end

  assign bus.req_ready    = (r_state == S_IDLE);
  assign bus.dmem_read    = r_read;
  assign bus.dmem_write   = r_write;
  assign bus.dmem_address = r_addr;
  assign bus.dmem_wmask   = r_wmask;
  assign bus.dmem_wdata   = r_wdata;
  assign bus.wb_valid     = r_wb_valid;
  assign bus.wb_rd        = r_wb_rd;
  assign bus.wb_rdata     = r_wb_rdata;
  assign bus.err_misalign = r_err_mis;
  assign bus.err_illegal  = r_err_ill;
  assign bus.err_timeout  = r_err_to;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed + random bench for mem_access_unit against a byte-level memory model.
module tb_mem_access_unit;

  localparam int unsigned TO = 255;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [31:0] ref_mem [16];
  logic [31:0] bmem    [16];
  logic [31:0] obs;

  mem_access_unit_if bus();

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_checks++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic bit legal(input bit ld, input bit st, input logic [2:0] f3);
    if (ld == st) return 0;
    if (ld) return (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b100 || f3 == 3'b101);
    return (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010);
  endfunction

  // Value a load of this width/sign at byte offset off must produce from word.
  function automatic logic [31:0] exp_load(input logic [31:0] word, input logic [2:0] f3, input int off);
    longint unsigned w;
    longint          v;
    int              sz;
    bit              sgn;
    sz  = size_of(f3);
    sgn = (f3 == 3'b000 || f3 == 3'b001);
    w   = word;
    v   = longint'((w >> (8 * off)) & ((64'd1 << (8 * sz)) - 64'd1));
    if (sgn && v >= (64'sd1 <<< (8 * sz - 1))) v = v - (64'sd1 <<< (8 * sz));
    return v[31:0];
  endfunction

  function automatic logic [3:0] exp_mask(input logic [2:0] f3, input int off);
    logic [3:0] m;
    int         sz;
    m  = 4'b0000;
    sz = size_of(f3);
    for (int i = 0; i < 4; i++) if (i >= off && i < off + sz) m[i] = 1'b1;
    return m;
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_rd"},    bus.dmem_read, 0);
    chk({tag, "_wr"},    bus.dmem_write, 0);
    chk({tag, "_addr"},  bus.dmem_address, 0);
    chk({tag, "_mask"},  bus.dmem_wmask, 0);
    chk({tag, "_wdat"},  bus.dmem_wdata, 0);
    chk({tag, "_wbv"},   bus.wb_valid, 0);
    chk({tag, "_wbrd"},  bus.wb_rd, 0);
    chk({tag, "_wbdat"}, bus.wb_rdata, 0);
    chk({tag, "_emis"},  bus.err_misalign, 0);
    chk({tag, "_eill"},  bus.err_illegal, 0);
    chk({tag, "_eto"},   bus.err_timeout, 0);
    chk({tag, "_rdy"},   bus.req_ready, 1);
  endtask

  // Issues one op in the current cycle; returns in the writeback/error-visible cycle.
  task automatic run_op(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd, input int lat,
                        input bit junk, output logic [31:0] o);
    int          off, idx, n_wait;
    bit          ok, mis, tmo;
    logic [3:0]  em;
    logic [31:0] ew, eaddr;
    off   = int'(addr[1:0]);
    idx   = int'(addr[5:2]);
    ok    = legal(ld, st, f3);
    mis   = ok && ((off % size_of(f3)) != 0);
    tmo   = (lat >= int'(TO));
    em    = exp_mask(f3, off);
    ew    = wdata << (8 * off);
    eaddr = addr & 32'hFFFF_FFFC;
    o     = 32'hxxxx_xxxx;

    bus.req_valid  = 1'b1;
    bus.req_load   = ld;
    bus.req_store  = st;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_rd     = rd;
    chk("ready_at_issue", bus.req_ready, 1);
    tick();
    bus.req_valid = 1'b0;
    chk("wb_pulse_one_cycle", bus.wb_valid, 0);
    chk("eto_idle", bus.err_timeout, 0);

    if (!ok || mis) begin
      chk("err_illegal", bus.err_illegal, !ok);
      chk("err_misalign", bus.err_misalign, mis);
      chk("err_no_read", bus.dmem_read, 0);
      chk("err_no_write", bus.dmem_write, 0);
      chk("err_stay_idle", bus.req_ready, 1);
      return;
    end

    chk("ok_no_eill", bus.err_illegal, 0);
    chk("ok_no_emis", bus.err_misalign, 0);
    chk("wait_not_ready", bus.req_ready, 0);
    chk("strobe_rd", bus.dmem_read, ld);
    chk("strobe_wr", bus.dmem_write, st);
    chk("dmem_addr", bus.dmem_address, eaddr);
    if (st) begin
      chk("wmask", bus.dmem_wmask, em);
      chk("wdata", bus.dmem_wdata, ew);
    end

    if (junk) begin
      bus.req_valid  = 1'b1;
      bus.req_load   = 1'($urandom_range(0, 1));
      bus.req_store  = 1'($urandom_range(0, 1));
      bus.req_funct3 = 3'($urandom_range(0, 7));
      bus.req_addr   = $urandom;
      bus.req_wdata  = $urandom;
      bus.req_rd     = 5'($urandom_range(0, 31));
    end

    n_wait = tmo ? int'(TO) - 1 : lat;
    for (int i = 0; i < n_wait; i++) begin
      tick();
      chk("hold_rd", bus.dmem_read, ld);
      chk("hold_wr", bus.dmem_write, st);
      chk("hold_addr", bus.dmem_address, eaddr);
      chk("hold_no_wb", bus.wb_valid, 0);
      chk("hold_not_ready", bus.req_ready, 0);
      if (st) begin
        chk("hold_wmask", bus.dmem_wmask, em);
        chk("hold_wdata", bus.dmem_wdata, ew);
      end
    end

    if (tmo) begin
      tick();
      bus.req_valid = 1'b0;
      chk("to_rd_low", bus.dmem_read, 0);
      chk("to_wr_low", bus.dmem_write, 0);
      chk("to_pulse", bus.err_timeout, 1);
      chk("to_no_wb", bus.wb_valid, 0);
      chk("to_ready", bus.req_ready, 1);
      tick();
      chk("to_pulse_end", bus.err_timeout, 0);
      chk("to_no_wb_after", bus.wb_valid, 0);
      return;
    end

    bus.dmem_resp  = 1'b1;
    bus.dmem_rdata = ld ? bmem[idx] : $urandom;
    if (st) begin
      for (int b = 0; b < 4; b++)
        if (bus.dmem_wmask[b]) bmem[idx][8*b +: 8] = bus.dmem_wdata[8*b +: 8];
    end
    tick();
    bus.dmem_resp  = 1'b0;
    bus.req_valid  = 1'b0;
    bus.dmem_rdata = $urandom;
    chk("wb_valid", bus.wb_valid, 1);
    chk("wb_rd", bus.wb_rd, rd);
    chk("wb_rdata", bus.wb_rdata, ld ? exp_load(ref_mem[idx], f3, off) : 32'd0);
    chk("done_rd_low", bus.dmem_read, 0);
    chk("done_wr_low", bus.dmem_write, 0);
    chk("done_ready", bus.req_ready, 1);
    o = bus.wb_rdata;
    if (st) begin
      for (int b = 0; b < 4; b++)
        if (em[b]) ref_mem[idx][8*b +: 8] = ew[8*b +: 8];
    end
  endtask

  initial begin
    logic [2:0]  f3;
    bit          ld, st;
    logic [31:0] a;
    int          kind;

    bus.req_valid  = 1'b0;
    bus.req_load   = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bus.req_rd     = 5'd0;
    bus.dmem_rdata = 32'd0;
    bus.dmem_resp  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      bmem[i]    = ref_mem[i];
    end
    ref_mem[0] = 32'hDEADBEEF;
    bmem[0]    = 32'hDEADBEEF;

    #2 rst_n = 1'b0;
    #1 chk_quiet("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk_quiet("post_reset");

    run_op(1, 0, 3'b010, 32'h100, 0, 5'd5, 1, 0, obs);
    chk("lw_0x100", obs, 32'hDEADBEEF);
    run_op(1, 0, 3'b000, 32'h103, 0, 5'd6, 1, 0, obs);
    chk("lb_0x103", obs, 32'hFFFFFFDE);
    run_op(1, 0, 3'b100, 32'h103, 0, 5'd7, 0, 0, obs);
    chk("lbu_0x103", obs, 32'h000000DE);
    run_op(1, 0, 3'b101, 32'h102, 0, 5'd8, 2, 0, obs);
    chk("lhu_0x102", obs, 32'h0000DEAD);
    run_op(0, 1, 3'b001, 32'h102, 32'h1234ABCD, 5'd9, 1, 0, obs);
    run_op(1, 0, 3'b010, 32'h100, 0, 5'd10, 1, 0, obs);
    chk("lw_after_sh", obs, 32'hABCDBEEF);
    run_op(0, 1, 3'b000, 32'h109, 32'h00000055, 5'd11, 0, 0, obs);
    run_op(1, 0, 3'b000, 32'h109, 0, 5'd12, 0, 0, obs);
    chk("lb_after_sb", obs, 32'h00000055);

    run_op(1, 0, 3'b010, 32'h101, 0, 5'd1, 1, 0, obs);
    run_op(1, 0, 3'b001, 32'h103, 0, 5'd1, 1, 0, obs);
    run_op(0, 1, 3'b010, 32'h102, 32'h1, 5'd1, 1, 0, obs);
    run_op(1, 0, 3'b011, 32'h100, 0, 5'd1, 1, 0, obs);
    run_op(0, 1, 3'b100, 32'h100, 32'h1, 5'd1, 1, 0, obs);
    run_op(1, 1, 3'b010, 32'h100, 32'h1, 5'd1, 1, 0, obs);
    run_op(0, 0, 3'b010, 32'h100, 32'h1, 5'd1, 1, 0, obs);

    bus.dmem_resp = 1'b1;
    tick();
    bus.dmem_resp = 1'b0;
    tick();
    chk("stray_resp_no_wb", bus.wb_valid, 0);
    chk("stray_resp_no_rd", bus.dmem_read, 0);

    run_op(1, 0, 3'b010, 32'h100, 0, 5'd13, 3, 1, obs);
    chk("lw_with_held_req", obs, 32'hABCDBEEF);

    run_op(1, 0, 3'b010, 32'h108, 0, 5'd14, int'(TO), 0, obs);
    run_op(1, 0, 3'b010, 32'h108, 0, 5'd15, int'(TO) - 1, 0, obs);
    chk("lw_at_last_cycle", obs, ref_mem[2]);

    // Abandon an op mid-WAIT via reset; a late response must not complete it.
    bus.req_valid  = 1'b1;
    bus.req_load   = 1'b1;
    bus.req_store  = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h104;
    bus.req_rd     = 5'd20;
    tick();
    bus.req_valid = 1'b0;
    chk("mid_wait_strobe", bus.dmem_read, 1);
    tick();
    #2 rst_n = 1'b0;
    #1 chk_quiet("async_reset");
    tick();
    rst_n = 1'b1;
    bus.dmem_resp  = 1'b1;
    bus.dmem_rdata = 32'hCAFEF00D;
    tick();
    bus.dmem_resp = 1'b0;
    chk_quiet("late_resp_1");
    tick();
    chk_quiet("late_resp_2");

    run_op(1, 0, 3'b010, 32'h100, 0, 5'd21, 1, 0, obs);
    chk("b2b_first", obs, 32'hABCDBEEF);
    run_op(1, 0, 3'b010, 32'h104, 0, 5'd22, 0, 0, obs);
    chk("b2b_second", obs, ref_mem[1]);

    for (int k = 0; k < 60; k++) begin
      kind = $urandom_range(0, 9);
      ld = 1'b1;
      st = 1'b0;
      case (kind)
        0: f3 = 3'b000;
        1: f3 = 3'b001;
        2: f3 = 3'b010;
        3: f3 = 3'b100;
        4: f3 = 3'b101;
        5: begin f3 = 3'b000; ld = 0; st = 1; end
        6: begin f3 = 3'b001; ld = 0; st = 1; end
        7: begin f3 = 3'b010; ld = 0; st = 1; end
        8: f3 = ($urandom_range(0, 1) != 0) ? 3'b011 : 3'b110;
        default: begin
          f3 = 3'($urandom_range(0, 7));
          ld = 1'($urandom_range(0, 1));
          st = ld;
        end
      endcase
      a = 32'h100 + 32'($urandom_range(0, 63));
      run_op(ld, st, f3, a, $urandom, 5'($urandom_range(0, 31)), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), obs);
      if ($urandom_range(0, 3) == 0) tick();
    end

    tick();
    chk("final_idle_ready", bus.req_ready, 1);
    chk("final_no_wb", bus.wb_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
